ps2_move_decoder: RTL

Converts the raw PS/2 byte stream from `ps2_rx` into debounced player-move requests for the collision stage. Tracks make/break/extended prefixes, maintains a held-key mask for WASD and arrow keys, and issues one move on each key press. While a key stays held, it auto-repeats at a frame-based rate. Sits between `ps2_rx` and `collision_detector`, replacing the combinational `move_control` path with a valid/ready handshake.

---
 rtl/game_pkg.sv | 77 +++++++
 rtl/ps2_scan_parser.sv | 75 +++++++
 rtl/ps2_move_decoder.sv | 102 ++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared game constants: move encodings, PS/2 scan codes, parser states, key map helpers.
package game_pkg;

  localparam int unsigned MOVE_W = 3;
  localparam int unsigned KEY_W  = 2;

  localparam logic [MOVE_W-1:0] MOVE_NONE  = 3'd0;
  localparam logic [MOVE_W-1:0] MOVE_UP    = 3'd1;
  localparam logic [MOVE_W-1:0] MOVE_DOWN  = 3'd2;
  localparam logic [MOVE_W-1:0] MOVE_LEFT  = 3'd3;
  localparam logic [MOVE_W-1:0] MOVE_RIGHT = 3'd4;

  // Bit positions inside the held-key mask {right, left, down, up}
  localparam logic [KEY_W-1:0] KEY_UP    = 2'd0;
  localparam logic [KEY_W-1:0] KEY_DOWN  = 2'd1;
  localparam logic [KEY_W-1:0] KEY_LEFT  = 2'd2;
  localparam logic [KEY_W-1:0] KEY_RIGHT = 2'd3;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } parser_state_t;

  typedef struct packed {
    logic             hit;
    logic [KEY_W-1:0] idx;
  } key_map_t;

  // Translate a scan code into a held-mask index; ext selects the E0-prefixed table.
  function automatic key_map_t map_key(input logic [7:0] code, input logic ext);
    key_map_t km;
    km = '0;
    if (!ext) begin
      case (code)
        SC_W:    km = '{hit: 1'b1, idx: KEY_UP};
        SC_S:    km = '{hit: 1'b1, idx: KEY_DOWN};
        SC_A:    km = '{hit: 1'b1, idx: KEY_LEFT};
        SC_D:    km = '{hit: 1'b1, idx: KEY_RIGHT};
        default: km = '0;
      endcase
    end else begin
      case (code)
        SC_UP:    km = '{hit: 1'b1, idx: KEY_UP};
        SC_DOWN:  km = '{hit: 1'b1, idx: KEY_DOWN};
        SC_LEFT:  km = '{hit: 1'b1, idx: KEY_LEFT};
        SC_RIGHT: km = '{hit: 1'b1, idx: KEY_RIGHT};
        default:  km = '0;
      endcase
    end
    return km;
  endfunction

  // Fixed priority up > down > left > right over the held mask.
  function automatic logic [MOVE_W-1:0] sel_move(input logic [3:0] held);
    logic [MOVE_W-1:0] mv;
    mv = MOVE_NONE;
    if (held[KEY_UP])         mv = MOVE_UP;
    else if (held[KEY_DOWN])  mv = MOVE_DOWN;
    else if (held[KEY_LEFT])  mv = MOVE_LEFT;
    else if (held[KEY_RIGHT]) mv = MOVE_RIGHT;
    return mv;
  endfunction

endpackage

// File: rtl/ps2_scan_parser.sv
// PS/2 prefix parser: tracks E0/F0 prefixes and emits one-cycle key make/break events.
// Event outputs are decoded from the current byte so the held mask can update on the same edge.
module ps2_scan_parser
  import game_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_done_tick,
  input  logic [7:0]       rx_data,
  output logic             key_evt,
  output logic [KEY_W-1:0] key_idx,
  output logic             key_make
);

  parser_state_t state_q;
  parser_state_t state_d;
  key_map_t      km;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: prefix tracking, advancing only on a received byte
  always_comb begin
    state_d = state_q;
    if (rx_done_tick) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_data == SC_EXT)      state_d = ST_EXT;
          else if (rx_data == SC_BRK) state_d = ST_BRK;
          else                        state_d = ST_IDLE;
        end
        ST_EXT:     state_d = (rx_data == SC_BRK) ? ST_EXT_BRK : ST_IDLE;
        ST_BRK:     state_d = ST_IDLE;
        ST_EXT_BRK: state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs: decode the byte terminating a make or break sequence
  always_comb begin
    key_evt  = 1'b0;
    key_make = 1'b0;
    km       = map_key(rx_data, (state_q == ST_EXT) || (state_q == ST_EXT_BRK));
    key_idx  = km.idx;
    if (rx_done_tick) begin
      case (state_q)
        ST_IDLE: begin
          if ((rx_data != SC_EXT) && (rx_data != SC_BRK)) begin
            key_evt  = km.hit;
            key_make = 1'b1;
          end
        end
        ST_EXT: begin
          if (rx_data != SC_BRK) begin
            key_evt  = km.hit;
            key_make = 1'b1;
          end
        end
        ST_BRK, ST_EXT_BRK: begin
          key_evt  = km.hit;
          key_make = 1'b0;
        end
        default: begin
          key_evt  = 1'b0;
          key_make = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/ps2_move_decoder.sv
// PS/2 move decoder: held-key mask, frame-based auto-repeat and a valid/ready move request slot.
module ps2_move_decoder
  import game_pkg::*;
#(
  parameter int unsigned REPEAT_FRAMES = 8,
  parameter int unsigned CNT_W         = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_done_tick,
  input  logic [7:0]        rx_data,
  input  logic              frame_tick,
  output logic              move_valid,
  output logic [MOVE_W-1:0] move,
  input  logic              move_ready,
  output logic [3:0]        key_held
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REPEAT_FRAMES - 1);

  logic             key_evt;
  logic [KEY_W-1:0] key_idx;
  logic             key_make;

  logic [CNT_W-1:0] rep_cnt;
  logic             press_pending;
  logic             repeat_due;

  logic new_press_c;
  logic any_held_c;
  logic wrap_c;
  logic slot_free_c;
  logic issue_c;
  logic load_c;

  ps2_scan_parser u_parser (
    .clk          (clk),
    .reset        (reset),
    .rx_done_tick (rx_done_tick),
    .rx_data      (rx_data),
    .key_evt      (key_evt),
    .key_idx      (key_idx),
    .key_make     (key_make)
  );

  // Control decode: fresh presses, repeat wrap and issue-slot availability
  always_comb begin
    any_held_c  = |key_held;
    new_press_c = key_evt & key_make & ~key_held[key_idx];
    wrap_c      = frame_tick & any_held_c & (rep_cnt == CNT_LAST);
    slot_free_c = ~move_valid | move_ready;
    issue_c     = slot_free_c & (press_pending | repeat_due);
    load_c      = issue_c & any_held_c;
  end

  // Held-key mask: makes set, breaks clear
  always_ff @(posedge clk) begin
    if (reset) begin
      key_held <= '0;
    end else if (key_evt) begin
      key_held[key_idx] <= key_make;
    end
  end

  // Repeat counter; a fresh press restarts the repeat interval
  always_ff @(posedge clk) begin
    if (reset) begin
      rep_cnt <= '0;
    end else if (new_press_c || !any_held_c) begin
      rep_cnt <= '0;
    end else if (frame_tick) begin
      rep_cnt <= wrap_c ? '0 : rep_cnt + CNT_W'(1);
    end
  end

  // Pending flags: a new set wins over the clear from a same-cycle issue
  always_ff @(posedge clk) begin
    if (reset) begin
      press_pending <= 1'b0;
      repeat_due    <= 1'b0;
    end else begin
      if (new_press_c)  press_pending <= 1'b1;
      else if (issue_c) press_pending <= 1'b0;
      if (wrap_c && !new_press_c) repeat_due <= 1'b1;
      else if (issue_c)           repeat_due <= 1'b0;
    end
  end

  // Request slot: holds move stable until accepted, reloads on the accept cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      move_valid <= 1'b0;
      move       <= MOVE_NONE;
    end else if (load_c) begin
      move_valid <= 1'b1;
      move       <= sel_move(key_held);
    end else if (move_valid && move_ready) begin
      move_valid <= 1'b0;
    end
  end

endmodule
